// File: rtl/ucsbece154a_memctl.sv
`timescale 1ns/1ps
// ucsbece154a_memctl: multi-cycle text/data memory controller.
// One outstanding access behind a req/ready/valid handshake; the access is
// performed LATENCY rising edges after the accept edge and answered with a
// one-cycle valid_o pulse.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_i           request, accepted when req_i && ready_o at a rising edge
//   we_i            1 = store, 0 = load
//   size_i          00 byte, 01 half, 10/11 word
//   unsigned_i      loads: 1 = zero-extend, 0 = sign-extend
//   a_i             byte address
//   wd_i            store data, right-aligned
//   ready_o         controller can accept a request this cycle
//   valid_o         one-cycle response pulse
//   rd_o            load result (0 for stores and faulting accesses)
//   fault_o         faulting-access flag, qualified by valid_o
//
// Optional feature macro: MEM_FAULT_EN. When defined, fault_o reports
// misaligned, out-of-range and store-to-text accesses; otherwise fault_o is
// tied low (faulting accesses are still suppressed and return 0).
//
// The read-only text image (text.dat) is supplied through TEXT_INIT, packed
// with word 0 in bits [31:0].
module ucsbece154a_memctl #(
    parameter int unsigned TEXT_SIZE  = 64,
    parameter int unsigned DATA_SIZE  = 64,
    parameter logic [31:0] TEXT_START = 32'h0040_0000,
    parameter logic [31:0] DATA_START = 32'h1000_0000,
    parameter int unsigned LATENCY    = 2,
    parameter logic [32*TEXT_SIZE-1:0] TEXT_INIT = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] a_i,
    input  logic [31:0] wd_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] rd_o,
    output logic        fault_o
);

    localparam int unsigned TEXT_AW    = (TEXT_SIZE > 1) ? $clog2(TEXT_SIZE) : 1;
    localparam int unsigned DATA_AW    = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] TEXT_BYTES = 32'(4 * TEXT_SIZE);
    localparam logic [31:0] DATA_BYTES = 32'(4 * DATA_SIZE);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [1:0]         lat_size;
    logic               lat_uns;
    logic [31:0]        lat_a;
    logic [31:0]        lat_wd;

    logic [31:0]        data_mem [DATA_SIZE];

    logic [31:0]        text_off;
    logic [31:0]        data_off;
    logic [TEXT_AW-1:0] text_idx;
    logic [DATA_AW-1:0] data_idx;
    logic               in_text;
    logic               in_data;
    logic               misalign;
    logic               fault_c;
    logic [31:0]        raw_word;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [31:0]        load_val;
    logic [3:0]         wmask;
    logic [31:0]        wdata;
    logic               commit;

    // Region decode and fault classification on the latched request.
    always_comb begin
        text_off = lat_a - TEXT_START;
        data_off = lat_a - DATA_START;
        text_idx = text_off[TEXT_AW+1:2];
        data_idx = data_off[DATA_AW+1:2];
        in_text  = (lat_a >= TEXT_START) && (text_off < TEXT_BYTES);
        in_data  = (lat_a >= DATA_START) && (data_off < DATA_BYTES);
        misalign = ((lat_size == 2'b01) && lat_a[0]) ||
                   (lat_size[1] && (lat_a[1:0] != 2'b00));
        fault_c  = misalign || !(in_text || in_data) || (lat_we && in_text);
    end

    // Load lane selection and extension.
    always_comb begin
        raw_word = in_text ? TEXT_INIT[{text_idx, 5'b00000} +: 32] : data_mem[data_idx];
        lane_b   = 8'h00;
        case (lat_a[1:0])
            2'd0:    lane_b = raw_word[7:0];
            2'd1:    lane_b = raw_word[15:8];
            2'd2:    lane_b = raw_word[23:16];
            default: lane_b = raw_word[31:24];
        endcase
        lane_h   = lat_a[1] ? raw_word[31:16] : raw_word[15:0];
        case (lat_size)
            2'b00:   load_val = {{24{~lat_uns & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{~lat_uns & lane_h[15]}}, lane_h};
            default: load_val = raw_word;
        endcase
    end

    // Store lane mask with right-aligned data replicated across lanes.
    always_comb begin
        case (lat_size)
            2'b00: begin
                wmask = 4'b0001 << lat_a[1:0];
                wdata = {4{lat_wd[7:0]}};
            end
            2'b01: begin
                wmask = lat_a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{lat_wd[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdata = lat_wd;
            end
        endcase
        commit = (state == BUSY) && (cnt == '0) && lat_we && !fault_c;
    end

    // Data array: not reset; a store dropped by reset never reaches here.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) data_mem[data_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Handshake FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            rd_o     <= 32'h0;
            fault_o  <= 1'b0;
            lat_we   <= 1'b0;
            lat_size <= 2'b00;
            lat_uns  <= 1'b0;
            lat_a    <= 32'h0;
            lat_wd   <= 32'h0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state   <= RESP;
                        ready_o <= 1'b1;
                        valid_o <= 1'b1;
                        rd_o    <= (fault_c || lat_we) ? 32'h0 : load_val;
`ifdef MEM_FAULT_EN
                        fault_o <= fault_c;
`else
                        fault_o <= 1'b0;
`endif
                    end
                end
                default: begin
                    // IDLE and RESP both accept; RESP accepts back-to-back.
                    if (req_i) begin
                        state    <= BUSY;
                        ready_o  <= 1'b0;
                        cnt      <= CNT_LOAD;
                        lat_we   <= we_i;
                        lat_size <= size_i;
                        lat_uns  <= unsigned_i;
                        lat_a    <= a_i;
                        lat_wd   <= wd_i;
                    end else begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154a_memctl.sv
`timescale 1ns/1ps
// Bench for ucsbece154a_memctl: a byte-level memory model predicts every
// cycle's outputs, and directed operations are pinned to literal results.
module tb_ucsbece154a_memctl;

    localparam int unsigned TSZ = 64;
    localparam int unsigned DSZ = 64;
    localparam logic [31:0] TS  = 32'h0040_0000;
    localparam logic [31:0] DS  = 32'h1000_0000;
    localparam int unsigned LAT = 2;
`ifdef MEM_FAULT_EN
    localparam logic FEN = 1'b1;
`else
    localparam logic FEN = 1'b0;
`endif

    function automatic logic [31:0] text_word(input int i);
        return 32'h8F00_3C00 | (32'(i) << 16) | 32'(i);
    endfunction

    function automatic logic [32*TSZ-1:0] gen_text();
        logic [32*TSZ-1:0] v;
        v = '0;
        for (int i = 0; i < int'(TSZ); i++) v[32*i +: 32] = text_word(i);
        return v;
    endfunction

    localparam logic [32*TSZ-1:0] TXT = gen_text();

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [31:0] a_i = 32'h0;
    logic [31:0] wd_i = 32'h0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] rd_o;
    logic        fault_o;

    int checks = 0;
    int failures = 0;

    ucsbece154a_memctl #(
        .TEXT_SIZE(TSZ), .DATA_SIZE(DSZ), .TEXT_START(TS), .DATA_START(DS),
        .LATENCY(LAT), .TEXT_INIT(TXT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .a_i(a_i), .wd_i(wd_i), .ready_o(ready_o),
        .valid_o(valid_o), .rd_o(rd_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  dmem [4*DSZ];
    bit          pend = 1'b0;
    int          due = 0;
    int          edge_n = 0;
    logic        p_we;
    logic [1:0]  p_sz;
    logic        p_uns;
    logic [31:0] p_a;
    logic [31:0] p_wd;
    logic        e_ready = 1'b1;
    logic        e_valid = 1'b0;
    logic [31:0] e_rd = 32'h0;
    logic        e_fault = 1'b0;

    task automatic model_access(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic flt);
        longint la, lt, ld;
        bit in_t, in_d;
        int n;
        logic [31:0] v, w, b;
        la = longint'({32'h0, a});
        lt = longint'({32'h0, TS});
        ld = longint'({32'h0, DS});
        in_t = (la >= lt) && (la < lt + 4 * longint'(TSZ));
        in_d = (la >= ld) && (la < ld + 4 * longint'(DSZ));
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        flt = ((a & 32'(n - 1)) != 0) || !(in_t || in_d) || (we && in_t);
        rd = 32'h0;
        if (!flt) begin
            if (we) begin
                for (int k = 0; k < n; k++) dmem[int'(a - DS) + k] = 8'(wd >> (8 * k));
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) begin
                    if (in_t) begin
                        w = text_word(int'(a - TS + 32'(k)) >> 2);
                        b = (w >> (8 * ((int'(a - TS) + k) % 4))) & 32'hFF;
                    end else begin
                        b = {24'h0, dmem[int'(a - DS) + k]};
                    end
                    v = v | (b << (8 * k));
                end
                if (!uns && n < 4 && (((v >> (8 * n - 1)) & 32'h1) != 0))
                    v = v | (32'hFFFF_FFFF << (8 * n));
                rd = v;
            end
        end
    endtask

    // Compare on every falling edge, then predict the effect of the next rising edge.
    initial begin
        logic [31:0] r;
        logic f;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0; e_ready = 1'b1; e_valid = 1'b0; e_rd = 32'h0; e_fault = 1'b0;
            end
            chk("cyc_ready", 32'(ready_o), 32'(e_ready));
            chk("cyc_valid", 32'(valid_o), 32'(e_valid));
            chk("cyc_rd", rd_o, e_rd);
            chk("cyc_fault", 32'(fault_o), 32'(e_fault));
            if (rst_n) begin
                edge_n++;
                e_valid = 1'b0;
                if (pend && due == edge_n) begin
                    model_access(p_we, p_sz, p_uns, p_a, p_wd, r, f);
                    e_rd = r;
                    e_fault = FEN & f;
                    e_valid = 1'b1;
                    pend = 1'b0;
                end
                if (req_i && e_ready) begin
                    pend = 1'b1; due = edge_n + int'(LAT);
                    p_we = we_i; p_sz = size_i; p_uns = unsigned_i; p_a = a_i; p_wd = wd_i;
                end
                e_ready = !pend;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic flt);
        int lat;
        @(posedge clk); #1;
        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; a_i = addr; wd_i = wd;
        @(posedge clk); #1;
        req_i = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (valid_o) break;
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT));
        rd = rd_o;
        flt = fault_o;
    endtask

    initial begin
        logic [31:0] rd;
        logic f;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_exp [4];
        logic [31:0] got [4];
        int nv, acc, guard;
        bit saw;

        b2b_addr[0] = 32'h1000_0004; b2b_exp[0] = 32'h1234_BEEF;
        b2b_addr[1] = 32'h1000_0008; b2b_exp[1] = 32'h1122_3344;
        b2b_addr[2] = 32'h1000_00FC; b2b_exp[2] = 32'hA5A5_0001;
        b2b_addr[3] = 32'h0040_0004; b2b_exp[3] = 32'h8F01_3C01;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'h1);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_rd", rd_o, 32'h0);

        do_op(1'b0, 2'b10, 1'b0, 32'h0040_0000, 32'h0, rd, f);
        chk("ld_text0", rd, 32'h8F00_3C00);
        chk("ld_text0_flt", 32'(f), 32'h0);

        do_op(1'b1, 2'b10, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, rd, f);
        chk("st_word_rd", rd, 32'h0);
        do_op(1'b0, 2'b00, 1'b0, 32'h1000_0005, 32'h0, rd, f);
        chk("ld_byte_s", rd, 32'hFFFF_FFBE);
        do_op(1'b0, 2'b00, 1'b1, 32'h1000_0005, 32'h0, rd, f);
        chk("ld_byte_u", rd, 32'h0000_00BE);

        do_op(1'b1, 2'b01, 1'b0, 32'h1000_0006, 32'h0000_1234, rd, f);
        do_op(1'b0, 2'b10, 1'b0, 32'h1000_0004, 32'h0, rd, f);
        chk("ld_after_sth", rd, 32'h1234_BEEF);
        do_op(1'b0, 2'b01, 1'b0, 32'h1000_0004, 32'h0, rd, f);
        chk("ld_half_s", rd, 32'hFFFF_BEEF);

        do_op(1'b0, 2'b10, 1'b0, 32'h1000_0002, 32'h0, rd, f);
        chk("mis_rd", rd, 32'h0);
        chk("mis_flt", 32'(f), 32'(FEN));
        do_op(1'b1, 2'b10, 1'b0, 32'h0040_0000, 32'h5555_5555, rd, f);
        chk("st_text_flt", 32'(f), 32'(FEN));
        do_op(1'b0, 2'b10, 1'b0, 32'h2000_0000, 32'h0, rd, f);
        chk("range_rd", rd, 32'h0);
        chk("range_flt", 32'(f), 32'(FEN));
        do_op(1'b0, 2'b10, 1'b0, 32'h0040_0000, 32'h0, rd, f);
        chk("text0_kept", rd, 32'h8F00_3C00);
        chk("text0_kept_flt", 32'(f), 32'h0);

        do_op(1'b0, 2'b00, 1'b0, 32'h0040_0001, 32'h0, rd, f);
        chk("ld_tbyte", rd, 32'h0000_003C);
        do_op(1'b0, 2'b01, 1'b0, 32'h0040_0006, 32'h0, rd, f);
        chk("ld_thalf_s", rd, 32'hFFFF_8F01);
        do_op(1'b0, 2'b10, 1'b0, 32'h0040_00FC, 32'h0, rd, f);
        chk("ld_text_last", rd, 32'h8F3F_3C3F);
        do_op(1'b0, 2'b10, 1'b0, 32'h0040_0100, 32'h0, rd, f);
        chk("text_end_flt", 32'(f), 32'(FEN));
        do_op(1'b1, 2'b10, 1'b0, 32'h1000_00FC, 32'hA5A5_0001, rd, f);
        do_op(1'b0, 2'b01, 1'b1, 32'h1000_00FE, 32'h0, rd, f);
        chk("ld_half_u_last", rd, 32'h0000_A5A5);
        do_op(1'b0, 2'b01, 1'b0, 32'h1000_0101, 32'h0, rd, f);
        chk("data_end_rd", rd, 32'h0);
        do_op(1'b1, 2'b10, 1'b0, 32'h1000_0008, 32'h1122_3344, rd, f);

        // back-to-back loads with req_i held high
        nv = 0; acc = 0; guard = 0;
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0; a_i = b2b_addr[0];
        while ((acc < 4 || nv < 4) && guard < 60) begin
            @(negedge clk);
            guard++;
            if (valid_o && nv < 4) begin
                got[nv] = rd_o;
                nv++;
            end
            if (ready_o && acc < 4 && req_i) begin
                @(posedge clk); #1;
                acc++;
                if (acc < 4) a_i = b2b_addr[acc];
                else req_i = 1'b0;
            end
        end
        req_i = 1'b0;
        chk("b2b_count", 32'(nv), 32'h4);
        for (int j = 0; j < 4; j++) begin
            if (j < nv) chk("b2b_rd", got[j], b2b_exp[j]);
        end

        // reset while a store is still pending
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; a_i = 32'h1000_0008; wd_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_i = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1 rst_n = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (valid_o) saw = 1'b1;
        end
        chk("rst_no_valid", 32'(saw), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_op(1'b0, 2'b10, 1'b0, 32'h1000_0008, 32'h0, rd, f);
        chk("st_dropped", rd, 32'h1122_3344);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
